// File: rtl/fft8_core.sv
// fft8_core: 8-point radix-2 decimation-in-time FFT engine on complex Q1.15 data.
// Loads 8 samples (stored bit-reversed), runs 3 stages x 4 butterflies at one per
// cycle using twiddles fetched from an external LUT, then streams bins 0..7 out.
// Optional macro FFT8_STAGE_SCALE_EN: halve every stage output (total gain 1/8).
// Without it, stage outputs saturate to the DW-bit range (gain 1).
module fft8_core #(
  parameter int DW = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2*DW-1:0] in_data,
  output logic [9:0]      tw_n,
  input  logic [31:0]     tw_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [2*DW-1:0] out_data,
  output logic [2:0]      out_index,
  output logic            busy
);

  typedef enum logic [1:0] {
    ST_LOAD    = 2'd0,
    ST_COMPUTE = 2'd1,
    ST_UNLOAD  = 2'd2
  } state_t;

  // Saturation limits and rounding constant for the 2*DW+1 bit product sums
  localparam logic signed [2*DW:0] PROD_MAX = {{(DW+2){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [2*DW:0] PROD_MIN = {{(DW+2){1'b1}}, {(DW-1){1'b0}}};
  localparam logic signed [2*DW:0] ROUND_K  = {{(DW+2){1'b0}}, 1'b1, {(DW-2){1'b0}}};

  state_t          state_q, state_d;
  logic [2:0]      cnt_q, cnt_d;
  logic [1:0]      stage_q, stage_d;
  logic [1:0]      bfly_q, bfly_d;
  logic [2:0]      out_idx_q, out_idx_d;
  logic [2*DW-1:0] mem_q [8];
  logic [2*DW-1:0] mem_d [8];

  logic [2:0]             p_idx, q_idx;
  logic [1:0]             tw_idx;
  logic signed [DW-1:0]   a_re, a_im, b_re, b_im, w_re, w_im;
  logic signed [2*DW:0]   prod_re, prod_im;
  logic signed [DW-1:0]   t_re, t_im;
  logic signed [DW:0]     sum_re, sum_im, dif_re, dif_im;
  logic [2*DW-1:0]        res_p, res_q;

  function automatic logic [2:0] bitrev3(input logic [2:0] j);
    return {j[0], j[1], j[2]};
  endfunction

  function automatic logic signed [2*DW:0] sx(input logic signed [DW-1:0] x);
    return {{(DW+1){x[DW-1]}}, x};
  endfunction

  // Round a Q2.30 product sum back to Q1.15 and clamp to the DW-bit range
  function automatic logic signed [DW-1:0] round_sat(input logic signed [2*DW:0] v);
    logic signed [2*DW:0] r;
    r = (v + ROUND_K) >>> (DW-1);
    if (r > PROD_MAX) return {1'b0, {(DW-1){1'b1}}};
    if (r < PROD_MIN) return {1'b1, {(DW-1){1'b0}}};
    return r[DW-1:0];
  endfunction

  // Bring a DW+1 bit butterfly sum back to DW bits
  function automatic logic signed [DW-1:0] reduce(input logic signed [DW:0] s);
`ifdef FFT8_STAGE_SCALE_EN
    return DW'(s >>> 1);
`else
    if (s[DW] != s[DW-1]) begin
      return s[DW] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
    end
    return s[DW-1:0];
`endif
  endfunction

  // Butterfly addressing: pair (p, q = p + 2^stage) and twiddle index for this step
  always_comb begin
    p_idx  = 3'd0;
    q_idx  = 3'd0;
    tw_idx = 2'd0;
    unique case (stage_q)
      2'd0: begin
        p_idx  = {bfly_q, 1'b0};
        q_idx  = {bfly_q, 1'b1};
        tw_idx = 2'd0;
      end
      2'd1: begin
        p_idx  = {bfly_q[1], 1'b0, bfly_q[0]};
        q_idx  = {bfly_q[1], 1'b1, bfly_q[0]};
        tw_idx = {bfly_q[0], 1'b0};
      end
      2'd2: begin
        p_idx  = {1'b0, bfly_q};
        q_idx  = {1'b1, bfly_q};
        tw_idx = bfly_q;
      end
      default: begin
        p_idx  = 3'd0;
        q_idx  = 3'd0;
        tw_idx = 2'd0;
      end
    endcase
  end

  assign a_re = mem_q[p_idx][2*DW-1:DW];
  assign a_im = mem_q[p_idx][DW-1:0];
  assign b_re = mem_q[q_idx][2*DW-1:DW];
  assign b_im = mem_q[q_idx][DW-1:0];
  assign w_re = tw_data[31:16];
  assign w_im = tw_data[15:0];

  // Complex multiply b*w, then a +/- t, reduced back to DW bits
  always_comb begin
    prod_re = sx(b_re) * sx(w_re) - sx(b_im) * sx(w_im);
    prod_im = sx(b_re) * sx(w_im) + sx(b_im) * sx(w_re);
    t_re    = round_sat(prod_re);
    t_im    = round_sat(prod_im);
    sum_re  = {a_re[DW-1], a_re} + {t_re[DW-1], t_re};
    sum_im  = {a_im[DW-1], a_im} + {t_im[DW-1], t_im};
    dif_re  = {a_re[DW-1], a_re} - {t_re[DW-1], t_re};
    dif_im  = {a_im[DW-1], a_im} - {t_im[DW-1], t_im};
    res_p   = {reduce(sum_re), reduce(sum_im)};
    res_q   = {reduce(dif_re), reduce(dif_im)};
  end

  // Next-state, memory writes and outputs; everything is held at zero while rst is high
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    stage_d   = stage_q;
    bfly_d    = bfly_q;
    out_idx_d = out_idx_q;
    mem_d     = mem_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_data  = '0;
    out_index = 3'd0;
    tw_n      = 10'd0;
    busy      = 1'b0;
    if (!rst) begin
      unique case (state_q)
        ST_LOAD: begin
          in_ready = 1'b1;
          if (in_valid) begin
            mem_d[bitrev3(cnt_q)] = in_data;
            cnt_d = cnt_q + 3'd1;
            if (cnt_q == 3'd7) state_d = ST_COMPUTE;
          end
        end
        ST_COMPUTE: begin
          busy         = 1'b1;
          tw_n         = {8'd0, tw_idx};
          mem_d[p_idx] = res_p;
          mem_d[q_idx] = res_q;
          bfly_d       = bfly_q + 2'd1;
          if (bfly_q == 2'd3) begin
            if (stage_q == 2'd2) begin
              stage_d = 2'd0;
              state_d = ST_UNLOAD;
            end else begin
              stage_d = stage_q + 2'd1;
            end
          end
        end
        ST_UNLOAD: begin
          out_valid = 1'b1;
          out_data  = mem_q[out_idx_q];
          out_index = out_idx_q;
          if (out_ready) begin
            out_idx_d = out_idx_q + 3'd1;
            if (out_idx_q == 3'd7) state_d = ST_LOAD;
          end
        end
        default: state_d = ST_LOAD;
      endcase
    end
  end

  // Control registers with synchronous reset; a reset mid-frame simply restarts loading
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_LOAD;
      cnt_q     <= 3'd0;
      stage_q   <= 2'd0;
      bfly_q    <= 2'd0;
      out_idx_q <= 3'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      stage_q   <= stage_d;
      bfly_q    <= bfly_d;
      out_idx_q <= out_idx_d;
    end
  end

  // Sample/bin register file; contents are don't-care after reset so it is never cleared
  always_ff @(posedge clk) begin
    for (int i = 0; i < 8; i++) mem_q[i] <= mem_d[i];
  end

endmodule

// File: doc/fft8_core.md
# fft8_core

8-point radix-2 decimation-in-time FFT engine that sits directly downstream of the 8-point twiddle LUT. It drives the LUT index, consumes the returned twiddle, and returns the transformed frame. It accepts one frame of 8 complex Q1.15 samples over a valid/ready stream and stores it bit-reversed. It then runs 3 stages × 4 butterflies, one butterfly per cycle, and streams out the 8 bins in natural order. It is the core of the pitch-analysis FFT path.

## Interface
Parameters:
- DW, 16, width of each real/imag component; sample word is {re[DW-1:0], im[DW-1:0]}, two's complement Q1.15.

Ports:
- clk  in  1  single clock, all logic rising-edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input sample valid.
- in_ready  out  1  core accepting samples (LOAD state only).
- in_data  in  2*DW  {re, im} input sample.
- tw_n  out  10  twiddle index to LUT; values 0..3 only.
- tw_data  in  32  {wr, wi} from LUT, combinational response to tw_n in the same cycle.
- out_valid  out  1  output bin valid (UNLOAD state only).
- out_ready  in  1  downstream accepts bin.
- out_data  out  2*DW  {re, im} bin value; 0 when out_valid=0.
- out_index  out  3  bin number of out_data, 0..7.
- busy  out  1  high during COMPUTE.

## Operation
- Storage: 8-entry register file of 2*DW words, combinational read, write on clk edge.
- States: LOAD → COMPUTE → UNLOAD → LOAD.
  - LOAD: in_ready=1. Each in_valid&&in_ready handshake writes sample j (j=0..7, arrival order) to entry bitrev3(j). On the 8th handshake, go to COMPUTE.
  - COMPUTE: stage s=0..2, butterfly k=0..3, one per cycle, 12 cycles total.
    - Group size h=2^s. Pair indices: p = (k/h)*2h + (k mod h), q = p+h.
    - tw_n = (k mod h) << (2-s).
    - Both results write back at the edge ending the cycle. After s=2,k=3, go to UNLOAD.
  - UNLOAD: out_valid=1, out_index starts at 0, out_data = mem[out_index]. Each out_valid&&out_ready advances out_index. The handshake at index 7 returns to LOAD.
- Butterfly arithmetic, with a=mem[p], b=mem[q], w=tw_data:
  - tr = br*wr − bi*wi and ti = br*wi + bi*wr, each computed at 2*DW+1 bits.
  - Add 2^14, arithmetic shift right 15, saturate to DW bits.
  - mem[p] = a + t and mem[q] = a − t, computed at DW+1 bits, then reduced to DW bits per the Configuration section.
- Twiddle convention is W = e^(−j2πn/8), giving a forward transform.
- Reset: state=LOAD, sample counter=0, out_index=0. Memory is not cleared (don't-care). Reset mid-frame aborts the frame with no partial output.

## Timing
- Reset values while rst=1: in_ready=0, out_valid=0, out_data=0, out_index=0, tw_n=0, busy=0.
- First cycle after rst deasserts: in_ready=1.
- Load: any in_valid gaps are allowed. If the 8th sample is accepted in cycle T, COMPUTE occupies cycles T+1..T+12 with busy=1, and out_valid first asserts in cycle T+13.
- tw_n is 0 outside COMPUTE.
- Unload: one bin per cycle with out_ready=1, so minimum 8 cycles. out_data and out_index hold stable while out_valid=1 and out_ready=0.
- After the index-7 handshake in cycle U, in_ready=1 in cycle U+1.
- Minimum frame period is 8+12+8 = 28 cycles.
- in_valid is ignored outside LOAD. out_ready is ignored outside UNLOAD.

## Configuration
- FFT8_STAGE_SCALE_EN defined: each stage's a±t is arithmetic-shifted right by 1 (floor) to DW bits. Total gain is 1/8, and overflow cannot occur.
- FFT8_STAGE_SCALE_EN undefined: a±t is saturated to [−2^(DW−1), 2^(DW−1)−1]. Gain is 1.

## Test plan
- Impulse, scaled build: x[0]=16384+0j, x[1..7]=0 → all 8 bins = 2048+0j exactly, out_index 0..7 in order.
- DC, scaled build: all x=4096+0j → X[0]=4096+0j, X[1..7]=0 (±1 LSB).
- Complex tone, scaled build: x[n]=8192·e^(+j2πn/8) (rounded) → X[1]≈8192+0j ±2 LSB, other bins |re|,|im| ≤ 2.
- Backpressure: drop out_ready for 5 cycles while out_index=3 → out_data and out_index stable, in_ready=0 throughout. Resume yields bins 3..7 with no loss or duplicates.
- Reset in COMPUTE (cycle T+6): busy=0, tw_n=0, out_valid=0 while rst=1, in_ready=1 on the cycle after release. The next impulse frame produces correct output.
- Unscaled build: all x=8192+0j → X[0] saturates to 32767+0j, X[1..7]=0. Verifies saturation.
